// File: rtl/axi_wr_burst_engine.sv
// Streams a FWFT FIFO into AXI4 INCR write bursts, splitting each command into
// bursts of at most MAX_BURST beats that never cross a 4 KB boundary.
module axi_wr_burst_engine #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [15:0]         cmd_beats,
  input  logic [DATA_W-1:0]   fifo_dout,
  input  logic                fifo_empty,
  output logic                fifo_rd_en,
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  output logic                done,
  output logic                err
);

  localparam int unsigned SIZE = $clog2(DATA_W / 8);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, FIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       rem_q, rem_d;
  logic [7:0]        awlen_q, awlen_d;
  logic [7:0]        beat_q, beat_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] cmd_addr_al;
  logic [8:0]        len;
  logic [ADDR_W-1:0] addr_step;
  logic [15:0]       rem_step;
  logic              in_unused;

  // Beats allowed from an aligned address: remaining, MAX_BURST and room to the 4 KB edge.
  function automatic logic [8:0] calc_len(input logic [11:0] a, input logic [15:0] rem);
    logic [16:0] room;
    logic [16:0] lim;
    room = 17'(4096 >> SIZE) - 17'(a >> SIZE);
    lim  = {1'b0, rem};
    if (lim > 17'(MAX_BURST)) lim = 17'(MAX_BURST);
    if (lim > room) lim = room;
    return 9'(lim);
  endfunction

  assign cmd_addr_al = {cmd_addr[ADDR_W-1:SIZE], {SIZE{1'b0}}};
  assign len         = {1'b0, awlen_q} + 9'd1;
  assign addr_step   = addr_q + (ADDR_W'(len) << SIZE);
  assign rem_step    = rem_q - 16'(len);
  assign in_unused   = ^{bresp[0], cmd_addr[SIZE-1:0]};

  assign awaddr  = addr_q;
  assign awlen   = awlen_q;
  assign awsize  = 3'(SIZE);
  assign awburst = 2'b01;
  assign wstrb   = '1;
  assign wdata   = fifo_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      awlen_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      awlen_q <= awlen_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    awlen_d    = awlen_q;
    beat_d     = beat_q;
    err_d      = err_q;
    cmd_ready  = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    wlast      = 1'b0;
    bready     = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d = cmd_addr_al;
          rem_d  = cmd_beats;
          if (cmd_beats == 16'd0) begin
            state_d = FIN;
          end else begin
            state_d = ADDR;
            awlen_d = 8'(calc_len(cmd_addr_al[11:0], cmd_beats) - 9'd1);
          end
        end
      end
      ADDR: begin
        awvalid = 1'b1;
        if (awready) begin
          state_d = DATA;
          beat_d  = '0;
        end
      end
      DATA: begin
        wvalid = !fifo_empty;
        wlast  = (beat_q == awlen_q);
        if (wvalid && wready) begin
          beat_d = beat_q + 8'd1;
          if (wlast) state_d = RESP;
        end
      end
      RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          addr_d = addr_step;
          rem_d  = rem_step;
          if (bresp[1]) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else if (rem_step == 16'd0) begin
            state_d = FIN;
          end else begin
            // Next burst length is sized from the post-increment address.
            state_d = ADDR;
            awlen_d = 8'(calc_len(addr_step[11:0], rem_step) - 9'd1);
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        err     = err_q;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    fifo_rd_en = wvalid && wready;
  end

endmodule
